// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared control-unit step constants and types
// Step width, last step and idle bus values shared with the control matrix.
package ctrl_pkg;

  localparam int CTRL_STEP_W   = 3;
  localparam int CTRL_MAX_STEP = 5;
  localparam int CTRL_NUM_OUT  = 2 ** CTRL_STEP_W;

  // All-inactive step bus for each output polarity
  localparam logic [CTRL_NUM_OUT-1:0] CTRL_BUS_IDLE_LOW  = '1;
  localparam logic [CTRL_NUM_OUT-1:0] CTRL_BUS_IDLE_HIGH = '0;

  typedef enum logic [2:0] {
    CAUSE_HOLD   = 3'd0,
    CAUSE_INC    = 3'd1,
    CAUSE_WRAP   = 3'd2,
    CAUSE_CLR    = 3'd3,
    CAUSE_LD     = 3'd4,
    CAUSE_LD_ERR = 3'd5
  } step_cause_e;

  function automatic logic cause_ends_instr(input step_cause_e cause);
    return (cause == CAUSE_WRAP) || (cause == CAUSE_CLR);
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - combinational SEL_W-to-NUM_OUT one-hot decoder
// Selects above NUM_OUT-1 or en_i=0 leave every output inactive.
module onehot_decoder #(
  parameter int SEL_W      = 3,
  parameter int NUM_OUT    = 2 ** SEL_W,
  parameter int ACTIVE_LOW = 1
) (
  input  logic [SEL_W-1:0]   sel_i,
  input  logic               en_i,
  output logic [NUM_OUT-1:0] y_o
);

  logic [NUM_OUT-1:0] act;

  always_comb begin
    act = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (en_i && (sel_i == SEL_W'(i))) begin
        act[i] = 1'b1;
      end
    end
  end

  assign y_o = (ACTIVE_LOW != 0) ? ~act : act;

endmodule

// File: rtl/step_decoder.sv
// rtl/step_decoder.sv - T-state step counter with registered one-hot step bus
// The decoder runs on the next-step value so y updates on the same edge as step.
module step_decoder
  import ctrl_pkg::*;
#(
  parameter int SEL_W      = CTRL_STEP_W,
  parameter int NUM_OUT    = 2 ** SEL_W,
  parameter int MAX_STEP   = CTRL_MAX_STEP,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               ld,
  input  logic [SEL_W-1:0]   ld_val,
  input  logic               out_en_n,
  output logic [SEL_W-1:0]   step,
  output logic [NUM_OUT-1:0] y,
  output logic               instr_done,
  output logic               ld_err
);

  localparam logic [SEL_W-1:0]   MAX_S  = SEL_W'(MAX_STEP);
  localparam logic [NUM_OUT-1:0] Y_ONE  = NUM_OUT'(1);
  localparam logic [NUM_OUT-1:0] Y_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_OUT-1:0] Y_RST  = (ACTIVE_LOW != 0) ? ~Y_ONE : Y_ONE;

  logic [SEL_W-1:0]   step_q, step_d;
  logic [NUM_OUT-1:0] y_q, y_d;
  logic               done_q, done_d;
  logic               ld_err_q, ld_err_d;
  step_cause_e        cause;

  // Priority ld > clr > en; reset is handled in the register block
  always_comb begin
    cause = CAUSE_HOLD;
    if (ld) begin
      cause = (ld_val <= MAX_S) ? CAUSE_LD : CAUSE_LD_ERR;
    end else if (clr) begin
      cause = CAUSE_CLR;
    end else if (en) begin
      cause = (step_q == MAX_S) ? CAUSE_WRAP : CAUSE_INC;
    end
  end

  always_comb begin
    step_d   = step_q;
    ld_err_d = ld_err_q;
    case (cause)
      CAUSE_INC:    step_d = step_q + SEL_W'(1);
      CAUSE_WRAP:   step_d = '0;
      CAUSE_CLR:    step_d = '0;
      CAUSE_LD:     step_d = ld_val;
      CAUSE_LD_ERR: begin
        step_d   = '0;
        ld_err_d = 1'b1;
      end
      default:      step_d = step_q;
    endcase
    done_d = cause_ends_instr(cause);
  end

  onehot_decoder #(
    .SEL_W      (SEL_W),
    .NUM_OUT    (NUM_OUT),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec (
    .sel_i (step_d),
    .en_i  (1'b1),
    .y_o   (y_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= '0;
      y_q      <= Y_RST;
      done_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      y_q      <= y_d;
      done_q   <= done_d;
      ld_err_q <= ld_err_d;
    end
  end

  // Output gate sits after the register and never touches the counter
  assign y          = out_en_n ? Y_IDLE : y_q;
  assign step       = step_q;
  assign instr_done = done_q;
  assign ld_err     = ld_err_q;

endmodule

// File: tb/tb_step_decoder.sv
// tb/tb_step_decoder.sv - randomized and directed check of step_decoder
// Two instances (active-low and active-high bus) share stimulus and one model.
module tb_step_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       ld = 1'b0;
  logic [2:0] ld_val = 3'd0;
  logic       out_en_n = 1'b0;

  logic [2:0] step_a, step_b;
  logic [7:0] y_a, y_b;
  logic       done_a, done_b, err_a, err_b;

  int tests = 0;
  int fails = 0;

  int m_step = 0;
  int m_done = 0;
  int m_err  = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  step_decoder #(.SEL_W(3), .NUM_OUT(8), .MAX_STEP(5), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ld(ld), .ld_val(ld_val),
    .out_en_n(out_en_n), .step(step_a), .y(y_a), .instr_done(done_a), .ld_err(err_a)
  );

  step_decoder #(.SEL_W(3), .NUM_OUT(8), .MAX_STEP(5), .ACTIVE_LOW(0)) dut_ah (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ld(ld), .ld_val(ld_val),
    .out_en_n(out_en_n), .step(step_b), .y(y_b), .instr_done(done_b), .ld_err(err_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: priority rst > ld > clr > en, wrap after step 5
  always @(posedge clk) begin
    if (rst) begin
      m_step = 0; m_done = 0; m_err = 0;
    end else if (ld) begin
      if (int'(ld_val) <= 5) m_step = int'(ld_val);
      else begin m_step = 0; m_err = 1; end
      m_done = 0;
    end else if (clr) begin
      m_step = 0; m_done = 1;
    end else if (en) begin
      m_step = (m_step + 1) % 6;
      m_done = (m_step == 0) ? 1 : 0;
    end else begin
      m_done = 0;
    end
    chk_on = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int hot;
      hot = 1 << m_step;
      chk("step_al", int'(step_a), m_step);
      chk("step_ah", int'(step_b), m_step);
      chk("y_al", int'(y_a), out_en_n ? 'hFF : ((~hot) & 'hFF));
      chk("y_ah", int'(y_b), out_en_n ? 'h00 : hot);
      chk("done_al", int'(done_a), m_done);
      chk("done_ah", int'(done_b), m_done);
      chk("err_al", int'(err_a), m_err);
      chk("err_ah", int'(err_b), m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit r, input bit e, input bit c, input bit l, input int v);
    rst = r; en = e; clr = c; ld = l; ld_val = 3'(v);
  endtask

  initial begin
    logic [7:0] tbl_al [6];
    logic [7:0] tbl_ah [6];
    tbl_al = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};
    tbl_ah = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};

    // Reset for two cycles
    set_in(1, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_step", int'(step_a), 0);
    chk("rst_y", int'(y_a), 'hFE);
    chk("rst_done", int'(done_a), 0);
    chk("rst_err", int'(err_a), 0);

    // Free run, 14 cycles
    set_in(0, 1, 0, 0, 0);
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk("run_step", int'(step_a), i % 6);
      chk("run_y_al", int'(y_a), int'(tbl_al[i % 6]));
      chk("run_y_ah", int'(y_b), int'(tbl_ah[i % 6]));
      chk("run_done", int'(done_a), (i % 6 == 0) ? 1 : 0);
    end

    // Early end at step 2
    while (step_a != 3'd2) tick();
    set_in(0, 1, 1, 0, 0);
    tick();
    chk("clr_step", int'(step_a), 0);
    chk("clr_y", int'(y_a), 'hFE);
    chk("clr_done", int'(done_a), 1);
    set_in(0, 1, 0, 0, 0);
    tick();
    chk("clr_resume", int'(step_a), 1);
    chk("clr_done_off", int'(done_a), 0);

    // Halt at step 3
    set_in(0, 0, 0, 1, 3);
    tick();
    set_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("halt_step", int'(step_a), 3);
    chk("halt_y", int'(y_a), 'hF7);

    // ld beats clr on the same edge
    set_in(0, 1, 1, 1, 4);
    tick();
    chk("prio_step", int'(step_a), 4);
    chk("prio_done", int'(done_a), 0);

    // Load bounds
    set_in(0, 0, 0, 1, 5);
    tick();
    chk("ld5_step", int'(step_a), 5);
    chk("ld5_err", int'(err_a), 0);
    set_in(0, 0, 0, 1, 7);
    tick();
    chk("ld7_step", int'(step_a), 0);
    chk("ld7_err", int'(err_a), 1);
    set_in(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("ld7_sticky", int'(err_a), 1);

    // Output gate at step 4
    set_in(0, 0, 0, 1, 4);
    tick();
    out_en_n = 1'b1;
    set_in(0, 1, 0, 0, 0);
    #1;
    chk("gate_y_al", int'(y_a), 'hFF);
    chk("gate_y_ah", int'(y_b), 'h00);
    tick();
    chk("gate_step", int'(step_a), 5);
    chk("gate_hold_y", int'(y_a), 'hFF);
    en = 1'b0;
    out_en_n = 1'b0;
    #1;
    chk("ungate_y_al", int'(y_a), 'hDF);
    chk("ungate_y_ah", int'(y_b), 'h20);

    // Reset mid-operation with ld and en asserted
    set_in(0, 0, 0, 1, 4);
    tick();
    set_in(1, 1, 0, 1, 2);
    tick();
    chk("mrst_step", int'(step_a), 0);
    chk("mrst_y", int'(y_a), 'hFE);
    chk("mrst_done", int'(done_a), 0);
    chk("mrst_err", int'(err_a), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 99) < 2);
      ld       = ($urandom_range(0, 99) < 10);
      clr      = ($urandom_range(0, 99) < 10);
      en       = ($urandom_range(0, 99) < 75);
      ld_val   = 3'($urandom_range(0, 7));
      out_en_n = ($urandom_range(0, 99) < 15);
      tick();
    end

    set_in(0, 0, 0, 0, 0);
    out_en_n = 1'b0;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
